// File: rtl/riscv_cpu_pkg.sv
// rtl/riscv_cpu_pkg.sv - shared core types: bus width, arbiter lock state, memory requester IDs
package riscv_cpu_pkg;

   localparam int DATA_WIDTH = 32;

   typedef enum logic {
      ARB,
      LOCKED
   } arb_state_e;

   typedef enum logic {
      REQ_INSTR = 1'b0,
      REQ_DATA  = 1'b1
   } mem_req_id_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - OBI-style request/response bundle for one memory port
interface mem_port_arbiter_if #(
   parameter int DW = 32
);
   logic          req;
   logic [31:0]   addr;
   logic          we;
   logic [3:0]    be;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
   // Fetch never writes, so its view omits the write-side signals.
   modport fetch_slave (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_id_fifo.sv
// rtl/mem_id_fifo.sv - in-order FIFO of requester IDs for granted-but-unanswered transactions
module mem_id_fifo
   import riscv_cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  mem_req_id_e                push_id,
   input  logic                       pop,
   output mem_req_id_e                head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   mem_req_id_e   slot_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = slot_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         slot_q[wr_ptr_q] <= push_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and LSU with data priority,
// grant-lock, starvation guard and in-order response routing
module mem_port_arbiter
   import riscv_cpu_pkg::*;
#(
   parameter int DATA_WIDTH      = riscv_cpu_pkg::DATA_WIDTH,
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   mem_port_arbiter_if.fetch_slave instr,
   mem_port_arbiter_if.slave       data,
   mem_port_arbiter_if.master      mem,
   output logic                    err_o
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_OUTSTANDING);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   arb_state_e    state_q;
   mem_req_id_e   lock_id_q;
   logic [SW-1:0] starve_cnt_q;
   logic [CW-1:0] cnt_q;
   mem_req_id_e   sel;
   mem_req_id_e   head_id;
   logic          sel_req;
   logic          sel_data;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   always_comb begin
      sel     = REQ_DATA;
      sel_req = 1'b0;
      if (state_q == LOCKED) begin
         sel     = lock_id_q;
         sel_req = (lock_id_q == REQ_DATA) ? data.req : instr.req;
      end else if (instr.req && (!data.req || starve_cnt_q == STARVE_MAX)) begin
         sel     = REQ_INSTR;
         sel_req = 1'b1;
      end else if (data.req) begin
         sel     = REQ_DATA;
         sel_req = 1'b1;
      end
   end

   // Gating with rst_ni keeps the bus quiet for the whole reset pulse even if requesters stay high.
   assign mem.req   = rst_ni && sel_req && !full;
   assign sel_data  = (sel == REQ_DATA);
   assign mem.addr  = sel_data ? data.addr : instr.addr;
   assign mem.we    = rst_ni && sel_req && sel_data && data.we;
   assign mem.be    = sel_data ? data.be : 4'b1111;
   assign mem.wdata = sel_data ? data.wdata : '0;

   assign push      = mem.req && mem.gnt;
   assign instr.gnt = push && (sel == REQ_INSTR);
   assign data.gnt  = push && sel_data;

   assign pop          = mem.rvalid && !empty;
   assign instr.rvalid = pop && (head_id == REQ_INSTR);
   assign data.rvalid  = pop && (head_id == REQ_DATA);
   assign instr.rdata  = mem.rdata;
   assign data.rdata   = mem.rdata;

   mem_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .push    (push),
      .push_id (sel),
      .pop     (pop),
      .head    (head_id),
      .count   (cnt_q),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ARB;
         lock_id_q <= REQ_INSTR;
      end else begin
         case (state_q)
            ARB: begin
               if (mem.req && !mem.gnt) begin
                  state_q   <= LOCKED;
                  lock_id_q <= sel;
               end
            end
            LOCKED: begin
               // A locked requester withdrawing is tolerated silently and simply unlocks.
               if (!sel_req || (mem.req && mem.gnt)) begin
                  state_q <= ARB;
               end
            end
            default: state_q <= ARB;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starve_cnt_q <= '0;
      end else if (!instr.req || instr.gnt) begin
         starve_cnt_q <= '0;
      end else if (starve_cnt_q != STARVE_MAX) begin
         starve_cnt_q <= starve_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_o <= 1'b0;
      end else if (mem.rvalid && empty) begin
         err_o <= 1'b1;
      end
   end

   assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= MAX_CNT);

endmodule
